dmux_registered: RTL and testbench

//   Registered 1-to-N demultiplexer with a valid/ready handshake on every side.

---
 rtl/dmux_registered.sv | 75 +++++++
 tb/tb_dmux_registered.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmux_registered.sv
// Registered 1-to-N demultiplexer: one producer, OUTPUTS single-word output slots,
// unicast or all-or-nothing broadcast, per-channel valid/ready backpressure.

module dmuxSlot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] loadData,
   output logic [WIDTH-1:0] slotData,
   output logic             slotValid
);
   // A load on the same edge as a drain wins, so the channel streams without bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slotData  <= '0;
         slotValid <= 1'b0;
      end else if (load) begin
         slotData  <= loadData;
         slotValid <= 1'b1;
      end else if (drain) begin
         slotValid <= 1'b0;
      end
   end
endmodule

module dmux_registered #(
   parameter int WIDTH   = 16,
   parameter int OUTPUTS = 4,
   parameter int SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         inData,
   input  logic [SEL_W-1:0]         inSelect,
   input  logic                     inBroadcast,
   input  logic                     inValid,
   output logic                     inReady,
   output logic [OUTPUTS*WIDTH-1:0] outData,
   output logic [OUTPUTS-1:0]       outValid,
   input  logic [OUTPUTS-1:0]       outReady,
   output logic                     busy
);
   logic [OUTPUTS-1:0]            free;
   logic [OUTPUTS-1:0]            load;
   logic [OUTPUTS-1:0][WIDTH-1:0] slotData;
   logic                          accept;

   // A slot being drained this cycle can take a new word on the same edge.
   assign free    = ~outValid | outReady;
   assign inReady = inBroadcast ? &free : free[inSelect];
   assign accept  = inValid && inReady;

   genvar i;
   generate
      for (i = 0; i < OUTPUTS; i++) begin : genSlot
         assign load[i] = accept && (inBroadcast || (inSelect == SEL_W'(i)));

         dmuxSlot #(.WIDTH(WIDTH)) uSlot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[i]),
            .drain     (outReady[i]),
            .loadData  (inData),
            .slotData  (slotData[i]),
            .slotValid (outValid[i])
         );
      end
   endgenerate

   assign outData = slotData;
   assign busy    = |outValid;
endmodule

// File: tb/tb_dmux_registered.sv
// Directed checks of the registered demux plus a randomized run against per-channel queues.

module tb_dmux_registered;
   localparam int WIDTH = 16;
   localparam int OUTPUTS = 4;
   localparam int SEL_W = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [WIDTH-1:0]         inData;
   logic [SEL_W-1:0]         inSelect;
   logic                     inBroadcast;
   logic                     inValid;
   logic                     inReady;
   logic [OUTPUTS*WIDTH-1:0] outData;
   logic [OUTPUTS-1:0]       outValid;
   logic [OUTPUTS-1:0]       outReady;
   logic                     busy;

   int nTests = 0;
   int nFail  = 0;

   logic [WIDTH-1:0] q [OUTPUTS][$];

   dmux_registered #(.WIDTH(WIDTH), .OUTPUTS(OUTPUTS), .SEL_W(SEL_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .inData      (inData),
      .inSelect    (inSelect),
      .inBroadcast (inBroadcast),
      .inValid     (inValid),
      .inReady     (inReady),
      .outData     (outData),
      .outValid    (outValid),
      .outReady    (outReady),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] chan(input int c);
      logic [OUTPUTS*WIDTH-1:0] v;
      v = outData;
      return v[c*WIDTH +: WIDTH];
   endfunction

   initial begin
      reset = 1'b1; inData = '0; inSelect = '0; inBroadcast = 1'b0;
      inValid = 1'b0; outReady = '0;
      #12;
      chk("rstValidAsserted", outValid, 4'b0000);
      reset = 1'b0;
      tick();
      chk("rstValid", outValid, 4'b0000);
      chk("rstData", outData, 64'h0);
      chk("rstBusy", busy, 1'b0);
      chk("rstReady", inReady, 1'b1);

      // 1: unicast to channel 2, one-cycle latency
      inValid = 1'b1; inSelect = 2; inData = 16'hA5A5;
      #1 chk("t1ReadyPre", inReady, 1'b1);
      tick();
      inValid = 1'b0;
      chk("t1Valid", outValid, 4'b0100);
      chk("t1Data2", chan(2), 16'hA5A5);
      chk("t1Busy", busy, 1'b1);
      #1 chk("t1ReadySel2", inReady, 1'b0);
      inSelect = 0;
      #1 chk("t1ReadySel0", inReady, 1'b1);

      // drain channel 2; data is retained
      outReady = 4'b0100;
      tick();
      outReady = '0;
      chk("drainValid", outValid, 4'b0000);
      chk("drainRetain", chan(2), 16'hA5A5);
      chk("drainBusy", busy, 1'b0);

      // 2: channel 1 streams 8 back-to-back words with simultaneous drain
      inValid = 1'b1; inSelect = 1; inData = 16'h1000;
      tick();
      outReady = 4'b0010;
      for (int k = 0; k < 8; k++) begin
         inData = 16'h1234 + 16'(k);
         #1 chk("t2Ready", inReady, 1'b1);
         tick();
         chk("t2Valid", outValid[1], 1'b1);
         chk("t2Data", chan(1), 16'h1234 + 16'(k));
      end
      inValid = 1'b0; outReady = '0;
      tick();
      chk("t2Hold", chan(1), 16'h123B);
      outReady = 4'b0010;
      tick();
      outReady = '0;

      // 3: broadcast stalls while channel 3 is full and not drained
      inValid = 1'b1; inSelect = 3; inData = 16'h3333;
      tick();
      inBroadcast = 1'b1; inData = 16'hBEEF; inSelect = 0;
      #1 chk("t3Stall", inReady, 1'b0);
      tick();
      chk("t3ValidStall", outValid, 4'b1000);
      chk("t3Data3", chan(3), 16'h3333);
      chk("t3Data0", chan(0), 16'h0000);
      chk("t3Data2", chan(2), 16'hA5A5);
      outReady = 4'b1000;
      #1 chk("t3ReadyGo", inReady, 1'b1);
      tick();
      inValid = 1'b0; inBroadcast = 1'b0; outReady = '0;
      chk("t3ValidAll", outValid, 4'b1111);
      chk("t3DataAll", outData, {4{16'hBEEF}});

      // 4: asynchronous reset mid-cycle
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("t4Valid", outValid, 4'b0000);
      chk("t4Data", outData, 64'h0);
      chk("t4Busy", busy, 1'b0);
      chk("t4Ready", inReady, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      chk("t4After", outValid, 4'b0000);

      // 5: random traffic against per-channel queues
      for (int cyc = 0; cyc < 10000; cyc++) begin
         logic expReady;
         logic [OUTPUTS-1:0] fr;
         for (int c = 0; c < OUTPUTS; c++) begin
            chk("rndValid", outValid[c], q[c].size() != 0);
            if (q[c].size() != 0) chk("rndData", chan(c), q[c][0]);
            if (q[c].size() > 1) chk("rndDepth", 64'(q[c].size()), 64'd1);
         end
         inValid     = 1'($urandom_range(0, 1));
         inSelect    = SEL_W'($urandom_range(0, OUTPUTS-1));
         inBroadcast = ($urandom_range(0, 7) == 0);
         inData      = WIDTH'($urandom);
         outReady    = OUTPUTS'($urandom);
         #1;
         for (int c = 0; c < OUTPUTS; c++)
            fr[c] = (q[c].size() == 0) || outReady[c];
         expReady = inBroadcast ? &fr : fr[inSelect];
         chk("rndReady", inReady, expReady);
         for (int c = 0; c < OUTPUTS; c++)
            if (q[c].size() != 0 && outReady[c]) void'(q[c].pop_front());
         if (inValid && expReady)
            for (int c = 0; c < OUTPUTS; c++)
               if (inBroadcast || inSelect == SEL_W'(c)) q[c].push_back(inData);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
